audio_mem_sequencer: RTL

AUDIO_MEM_SEQUENCER -- requirements
Module: audio_mem_sequencer

---
 rtl/audio_seq_pkg.sv | 23 ++
 rtl/audio_mem_sequencer_strobe.sv | 26 ++
 rtl/audio_mem_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/audio_seq_pkg.sv
// Shared encodings for the audio memory sequencer.
// Mode values, FSM state type and a saturating counter helper.
package audio_seq_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_PLAY = 2'b01;
  localparam logic [1:0] MODE_REC  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    REC_WAIT,
    REC_WR,
    PLAY_FETCH,
    PLAY_WAIT,
    PLAY_HOLD,
    DONE
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/audio_mem_sequencer_strobe.sv
// Synchroniser and falling-edge detector for active-low strobes.
// Idles high out of reset so no spurious event is produced.
module strobe_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic pulse
);

  logic [1:0] sync;
  logic       prev;

  // Two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      prev <= 1'b1;
    end else begin
      sync <= {sync[0], strobe};
      prev <= sync[1];
    end
  end

  assign pulse = prev & ~sync[1];

endmodule

// File: rtl/audio_mem_sequencer.sv
// Record/playback sequencer between frame-based audio and word RAM.
// Build option: define AUDIO_SEQ_LOOP_EN to wrap playback forever.
module audio_mem_sequencer #(
  parameter int SAMPLE_W = 16,
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 mode,
  input  logic [ADDR_W-1:0]          max_addr,
  input  logic                       ram_rdy,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [SAMPLE_W-1:0]        ram_wdata,
  output logic                       ram_we,
  output logic                       ram_rd_req,
  input  logic                       ram_rd_pres,
  input  logic [SAMPLE_W-1:0]        ram_rdata,
  output logic                       ram_rd_ack,
  input  logic                       s_end,
  input  logic                       s_req,
  input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
  output logic [NUM_CH*SAMPLE_W-1:0] dac_data,
  output logic [1:0]                 led,
  output logic                       done,
  output logic [7:0]                 overrun_cnt,
  output logic [7:0]                 underrun_cnt
);

  import audio_seq_pkg::*;

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef AUDIO_SEQ_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  state_t state;
  state_t state_next;

  logic [CH_W-1:0] ch;
  logic            end_flag;
  logic            end_ev;
  logic            req_ev;
  logic            rec_st;
  logic            play_st;
  logic            abort;
  logic            ch_last;
  logic            at_max;

  logic [NUM_CH-1:0][SAMPLE_W-1:0] fbuf;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] pbuf;

  strobe_edge_det u_end_det (
    .clk    (clk),
    .reset  (reset),
    .strobe (s_end),
    .pulse  (end_ev)
  );

  strobe_edge_det u_req_det (
    .clk    (clk),
    .reset  (reset),
    .strobe (s_req),
    .pulse  (req_ev)
  );

  assign rec_st  = (state == REC_WAIT) || (state == REC_WR);
  assign play_st = (state == PLAY_FETCH) || (state == PLAY_WAIT)
                || (state == PLAY_HOLD);
  assign abort   = (rec_st && mode != MODE_REC)
                || (play_st && mode != MODE_PLAY);
  assign ch_last = (ch == CH_W'(NUM_CH - 1));
  assign at_max  = (ram_addr == max_addr);

  assign led       = {rec_st, play_st};
  assign done      = (state == DONE);
  assign ram_wdata = ram_we ? fbuf[ch] : '0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and single-cycle RAM strobes
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_rd_req = 1'b0;
    ram_rd_ack = 1'b0;
    unique case (state)
      IDLE: begin
        if (ram_rdy && mode == MODE_PLAY)     state_next = PLAY_FETCH;
        else if (ram_rdy && mode == MODE_REC) state_next = REC_WAIT;
      end
      REC_WAIT: begin
        if (end_ev) state_next = REC_WR;
      end
      REC_WR: begin
        if (ram_rdy) begin
          ram_we = 1'b1;
          if (at_max)       state_next = DONE;
          else if (ch_last) state_next = REC_WAIT;
        end
      end
      PLAY_FETCH: begin
        if (ram_rdy) begin
          ram_rd_req = 1'b1;
          state_next = PLAY_WAIT;
        end
      end
      PLAY_WAIT: begin
        ram_rd_req = 1'b1;
        if (ram_rd_pres) begin
          ram_rd_ack = 1'b1;
          if (ch_last || (at_max && !LOOP_EN)) state_next = PLAY_HOLD;
          else                                 state_next = PLAY_FETCH;
        end
      end
      PLAY_HOLD: begin
        if (req_ev) state_next = end_flag ? DONE : PLAY_FETCH;
      end
      DONE: begin
        if (mode == MODE_IDLE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A mode change abandons whatever transfer was in flight
    if (abort) begin
      state_next = IDLE;
      ram_we     = 1'b0;
      ram_rd_req = 1'b0;
      ram_rd_ack = 1'b0;
    end
  end

  // Address, channel index, frame buffers and error counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr     <= '0;
      ch           <= '0;
      end_flag     <= 1'b0;
      fbuf         <= '0;
      pbuf         <= '0;
      dac_data     <= '0;
      overrun_cnt  <= '0;
      underrun_cnt <= '0;
    end else begin
      if (mode == MODE_IDLE) begin
        overrun_cnt  <= '0;
        underrun_cnt <= '0;
      end else begin
        if (state == REC_WR && end_ev && !abort)
          overrun_cnt <= sat_inc(overrun_cnt);
        if ((state == PLAY_FETCH || state == PLAY_WAIT) && req_ev && !abort)
          underrun_cnt <= sat_inc(underrun_cnt);
      end
      unique case (state)
        IDLE: begin
          ram_addr <= '0;
          ch       <= '0;
          end_flag <= 1'b0;
        end
        REC_WAIT: begin
          if (end_ev && !abort) begin
            fbuf <= adc_data;
            ch   <= '0;
          end
        end
        REC_WR: begin
          if (ram_we) begin
            ch <= ch_last ? '0 : ch + 1'b1;
            if (!at_max) ram_addr <= ram_addr + 1'b1;
          end
        end
        PLAY_WAIT: begin
          if (ram_rd_ack) begin
            pbuf[ch] <= ram_rdata;
            ch       <= ch_last ? '0 : ch + 1'b1;
            if (!at_max)      ram_addr <= ram_addr + 1'b1;
            else if (LOOP_EN) ram_addr <= '0;
            else              end_flag <= 1'b1;
          end
        end
        PLAY_HOLD: begin
          if (req_ev && !abort) dac_data <= pbuf;
        end
        default: ;
      endcase
    end
  end

endmodule
